// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM encodings, Rx FIFO word layout and parity helper
//               for the Rx FIFO drain arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ORD1 = 3'd1,
    ORD2 = 3'd2,
    CAPT = 3'd3,
    DLVR = 3'd4
  } state_e;

  localparam int FE_BIT   = 11;
  localparam int BE_BIT   = 10;
  localparam int OE_BIT   = 9;
  localparam int PAR_BIT  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Number of consecutive read-command cycles issued to the Rx FIFO per word.
  localparam int RD_LAT = 2;

  function automatic logic parity_err(input logic [7:0] data, input logic par,
                                      input logic even);
    return ((^data) ^ par) != (even ? 1'b0 : 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_drain_arb_if.sv
// ============================================================================
// Module      : uart_rx_drain_arb_if
// Description : Rx FIFO, requester and error-counter signals of the drain
//               arbiter; master drives FIFO/requesters, slave is the block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_drain_arb_if #(
  parameter int N_REQ        = 2,
  parameter int FIFO_WIDTH_R = 12
);
  logic                    Rx_ready;
  logic                    RxFE;
  logic [FIFO_WIDTH_R-1:0] rx_word;
  logic                    receive_order;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        grant;
  logic                    rd_valid;
  logic [7:0]              rd_data;
  logic [3:0]              rd_err;
  logic [7:0]              err_cnt;
  logic                    err_clr;

  modport master (
    output Rx_ready, RxFE, rx_word, req, err_clr,
    input  receive_order, grant, rd_valid, rd_data, rd_err, err_cnt
  );

  modport slave (
    input  Rx_ready, RxFE, rx_word, req, err_clr,
    output receive_order, grant, rd_valid, rd_data, rd_err, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; search starts one past the last winner,
//               pointer advances only when enable is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [N_REQ-1:0] req_i,
  input  wire logic             enable_i,
  output logic      [N_REQ-1:0] grant_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, win_w;
  logic             found_w;
  int               idx_w;

  always_comb begin
    grant_o = '0;
    win_w   = ptr_q;
    found_w = 1'b0;
    idx_w   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = int'(ptr_q) + k;
      if (idx_w >= N_REQ) idx_w = idx_w - N_REQ;
      if (!found_w && req_i[idx_w]) begin
        found_w        = 1'b1;
        grant_o[idx_w] = 1'b1;
        win_w          = PTR_W'(idx_w);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (enable_i && found_w)
      ptr_d = (win_w == PTR_W'(N_REQ - 1)) ? '0 : win_w + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_drain_arb.sv
// ============================================================================
// Module      : uart_rx_drain_arb
// Description : Drains one Rx FIFO word at a time to round-robin requesters,
//               adding parity check and a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_drain_arb #(
  parameter int N_REQ        = 2,
  parameter int FIFO_WIDTH_R = 12,
  parameter int PARITY_EVEN  = 1
) (
  input wire logic          baud_clk,
  input wire logic          rst,
  uart_rx_drain_arb_if.slave bus
);
  import uart_pkg::*;

  state_e           state_q, state_d;
  logic             start_w;
  logic [N_REQ-1:0] arb_gnt_w;
  logic [N_REQ-1:0] grant_q;
  logic [7:0]       data_q;
  logic [3:0]       err_q;
  logic [7:0]       err_cnt_q;

  assign start_w = (state_q == IDLE) && bus.Rx_ready && !bus.RxFE && (|bus.req);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .clk      (baud_clk),
    .rst      (rst),
    .req_i    (bus.req),
    .enable_i (start_w),
    .grant_o  (arb_gnt_w)
  );

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Once started, the sequence runs to completion regardless of FIFO/req.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_w) state_d = ORD1;
      ORD1:    state_d = ORD2;
      ORD2:    state_d = CAPT;
      CAPT:    state_d = DLVR;
      DLVR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.receive_order = (state_q == ORD1) || (state_q == ORD2);
    bus.rd_valid      = (state_q == DLVR);
    bus.grant         = grant_q;
    bus.rd_data       = data_q;
    bus.rd_err        = err_q;
    bus.err_cnt       = err_cnt_q;
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      if (start_w)                grant_q <= arb_gnt_w;
      else if (state_q == DLVR)   grant_q <= '0;
      if (state_q == CAPT) begin
        data_q <= bus.rx_word[DATA_MSB:DATA_LSB];
        err_q  <= {bus.rx_word[FE_BIT], bus.rx_word[BE_BIT], bus.rx_word[OE_BIT],
                   parity_err(bus.rx_word[DATA_MSB:DATA_LSB], bus.rx_word[PAR_BIT],
                              PARITY_EVEN != 0)};
      end
    end
  end

  // A clear wins over a coincident error delivery.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst)
      err_cnt_q <= '0;
    else if (bus.err_clr)
      err_cnt_q <= '0;
    else if ((state_q == DLVR) && (|err_q) && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_drain_arb.sv
// ============================================================================
// Module      : tb_uart_rx_drain_arb
// Description : Randomized self-checking bench for uart_rx_drain_arb with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_drain_arb;
  import uart_pkg::*;

  localparam int N           = 2;
  localparam int PAR_EVEN    = 1;

  logic baud_clk = 1'b0;
  logic rst;

  uart_rx_drain_arb_if #(.N_REQ(N), .FIFO_WIDTH_R(12)) bus ();

  uart_rx_drain_arb #(.N_REQ(N), .FIFO_WIDTH_R(12), .PARITY_EVEN(PAR_EVEN)) dut (
    .baud_clk (baud_clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  always #5 baud_clk = ~baud_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_next = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  function automatic logic exp_pe(input logic [11:0] w);
    int ones = $countones(w[8:0]);
    return PAR_EVEN != 0 ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  task automatic idle_cycles(input int n);
    bus.req = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_gnt", 32'(bus.grant), 0);
      chk("idle_ro", 32'(bus.receive_order), 0);
    end
  endtask

  // Called from an IDLE sample window; leaves the bench in the next IDLE window.
  task automatic do_xfer(input logic [N-1:0] r, input logic [11:0] w,
                         input bit drop, input bit clr);
    int         win;
    logic [3:0] e;
    int         ro_cycles;
    bus.Rx_ready = 1'b1;
    bus.RxFE     = 1'b0;
    bus.req      = r;
    bus.rx_word  = w;
    bus.err_clr  = 1'b0;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && r[(rr_next + k) % N]) win = (rr_next + k) % N;
    rr_next = (win + 1) % N;
    e = {w[11], w[10], w[9], exp_pe(w)};
    ro_cycles = 0;

    tick();  // ORD1
    ro_cycles += int'(bus.receive_order);
    chk("ord1_ro", 32'(bus.receive_order), 1);
    chk("ord1_gnt", 32'(bus.grant), 32'(1) << win);
    if (drop) begin
      bus.req      = '0;
      bus.RxFE     = 1'b1;
      bus.Rx_ready = 1'b0;
    end
    tick();  // ORD2
    ro_cycles += int'(bus.receive_order);
    chk("ord2_gnt", 32'(bus.grant), 32'(1) << win);
    tick();  // CAPT
    ro_cycles += int'(bus.receive_order);
    chk("ro_len", 32'(ro_cycles), 32'(RD_LAT));
    chk("capt_vld", 32'(bus.rd_valid), 0);
    tick();  // DLVR
    chk("dlvr_vld", 32'(bus.rd_valid), 1);
    chk("dlvr_ro", 32'(bus.receive_order), 0);
    chk("dlvr_gnt", 32'(bus.grant), 32'(1) << win);
    chk("rd_data", 32'(bus.rd_data), 32'(w[7:0]));
    chk("rd_err", 32'(bus.rd_err), 32'(e));
    if (clr) begin
      bus.err_clr = 1'b1;
      exp_cnt = 0;
    end else if (e != 0 && exp_cnt < 255) begin
      exp_cnt++;
    end
    tick();  // IDLE
    bus.err_clr = 1'b0;
    chk("idle_vld", 32'(bus.rd_valid), 0);
    chk("idle_gnt0", 32'(bus.grant), 0);
    chk("err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
  endtask

  task automatic reset_model();
    rr_next = 0;
    exp_cnt = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    reset_model();
  endtask

  initial begin
    bus.Rx_ready = 1'b0;
    bus.RxFE     = 1'b1;
    bus.rx_word  = '0;
    bus.req      = '0;
    bus.err_clr  = 1'b0;
    rst          = 1'b1;
    repeat (2) tick();
    chk("rst_ro", 32'(bus.receive_order), 0);
    chk("rst_gnt", 32'(bus.grant), 0);
    chk("rst_vld", 32'(bus.rd_valid), 0);
    chk("rst_data", 32'(bus.rd_data), 0);
    chk("rst_err", 32'(bus.rd_err), 0);
    chk("rst_cnt", 32'(bus.err_cnt), 0);
    rst = 1'b0;
    reset_model();

    // Basic clean word to requester 0.
    do_xfer(2'b01, 12'h041, 1'b0, 1'b0);
    idle_cycles(1);

    // Both requesting, four words back to back from reset.
    apply_reset();
    for (int i = 0; i < 4; i++) do_xfer(2'b11, 12'($urandom), 1'b0, 1'b0);
    idle_cycles(1);

    // Framing + overrun error word.
    apply_reset();
    do_xfer(2'b10, 12'hA41, 1'b0, 1'b0);
    chk("err1010_cnt", 32'(bus.err_cnt), 1);

    // Empty FIFO blocks every request.
    bus.Rx_ready = 1'b1;
    bus.RxFE     = 1'b1;
    bus.req      = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("empty_ro", 32'(bus.receive_order), 0);
      chk("empty_gnt", 32'(bus.grant), 0);
    end

    // Reset pulsed in ORD2 abandons the transfer.
    bus.RxFE    = 1'b0;
    bus.rx_word = 12'h8FF;
    tick();  // ORD1
    tick();  // ORD2
    bus.req = '0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ro", 32'(bus.receive_order), 0);
    chk("mid_rst_gnt", 32'(bus.grant), 0);
    chk("mid_rst_vld", 32'(bus.rd_valid), 0);
    chk("mid_rst_data", 32'(bus.rd_data), 0);
    chk("mid_rst_err", 32'(bus.rd_err), 0);
    chk("mid_rst_cnt", 32'(bus.err_cnt), 0);
    #1 rst = 1'b0;
    reset_model();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_vld_after_rst", 32'(bus.rd_valid), 0);
    end
    do_xfer(2'b11, 12'h123, 1'b0, 1'b0);

    // Randomized traffic with req drops, FIFO glitches and clears.
    for (int i = 0; i < 60; i++) begin
      do_xfer(N'($urandom_range(1, 3)), 12'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(0, 2));
    end

    // Counter saturation, then a clear on an error delivery.
    for (int i = 0; i < 300; i++) begin
      if (i == 299) chk("err_sat", 32'(bus.err_cnt), 255);
      do_xfer(N'($urandom_range(1, 3)), 12'h800 | 12'($urandom_range(0, 255)),
              1'b0, (i == 299));
    end
    chk("err_after_clr", 32'(bus.err_cnt), 0);
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_drain_arb.md
UART_RX_DRAIN_ARB -- requirements
Module: uart_rx_drain_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 2, giving the number of requesters (2..4).
REQ-002 SHALL have parameter FIFO_WIDTH_R, default 12, giving the Rx FIFO word width ({FE,BE,OE,parity,data[7:0]}).
REQ-003 SHALL have parameter PARITY_EVEN, default 1: 1 selects even parity, 0 selects odd parity.
REQ-004 SHALL have baud_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have Rx_ready  input  1  the Rx FIFO is in its ready state.
REQ-007 SHALL have RxFE  input  1  the Rx FIFO is empty.
REQ-008 SHALL have rx_word  input  FIFO_WIDTH_R  Rx FIFO parallel output.
REQ-009 SHALL have receive_order  output  1  read command to the Rx FIFO.
REQ-010 SHALL have req  input  N_REQ  per-requester read request (level).
REQ-011 SHALL have grant  output  N_REQ  one-hot owner of the transfer in flight.
REQ-012 SHALL have rd_valid  output  1  one-cycle pulse: word delivered to the current grant.
REQ-013 SHALL have rd_data  output  8  delivered data byte (rx_word[7:0]).
REQ-014 SHALL have rd_err  output  4  {FE,BE,OE,PE}, where PE is the parity error computed by this block.
REQ-015 SHALL have err_cnt  output  8  count of delivered words with any rd_err bit set.
REQ-016 SHALL have err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-017 SHALL implement FSM states IDLE, ORD1, ORD2, CAPT, DLVR.
REQ-018 IDLE -> ORD1 SHALL occur when Rx_ready=1, RxFE=0 and |req=1; otherwise the FSM SHALL stay in IDLE.
REQ-019 On leaving IDLE, the block SHALL latch a round-robin grant: search starts at the index after the previous winner; index 0 is searched first after reset.
REQ-020 receive_order SHALL be high in ORD1 and ORD2 only, giving exactly 2 consecutive cycles, and low in all other states.
REQ-021 ORD1->ORD2->CAPT SHALL be unconditional; in CAPT the block SHALL register rx_word; CAPT->DLVR SHALL be unconditional.
REQ-022 In DLVR, rd_valid SHALL be 1 for one cycle, with rd_data and rd_err from the captured word; then DLVR->IDLE.
REQ-023 grant SHALL be held constant from ORD1 through DLVR and SHALL be 0 in IDLE.
REQ-024 Latency SHALL be 4 cycles from the IDLE decision cycle to rd_valid.
REQ-025 PE SHALL be (^data ^ parity) != (PARITY_EVEN ? 0 : 1).
REQ-026 A requester dropping req after the grant SHALL NOT abort the transfer; the word is still delivered with rd_valid.
REQ-027 The minimum spacing between transfers SHALL be 1 IDLE cycle, so a back-to-back request re-arbitrates each word.
REQ-028 err_cnt SHALL saturate at 255.
REQ-029 If err_clr coincides with an error delivery, err_clr SHALL win and err_cnt SHALL become 0.
REQ-030 RxFE or Rx_ready changing during ORD1..DLVR SHALL be ignored; the sequence completes.
REQ-031 Only one transfer SHALL be in flight at a time.

Reset
REQ-032 rst=1 SHALL asynchronously force: state=IDLE, receive_order=0, grant=0, rd_valid=0, rd_data=0, rd_err=0, err_cnt=0, round-robin pointer=0.
REQ-033 Reset during ORD1..DLVR SHALL abandon the transfer with no rd_valid emitted.

Structure
REQ-034 FSM state encodings, the word field bit positions (FE=11, BE=10, OE=9, PAR=8, DATA=7:0) and the RD_LAT=2 constant SHALL live in shared package uart_pkg.
REQ-035 The round-robin arbiter SHALL be a sub-module rr_arbiter (inputs: req, enable; output: one-hot grant; internal pointer).

Verification
REQ-036 Scenario: reset, then Rx_ready=1, RxFE=0, req=01, rx_word=0x041 -> receive_order high 2 cycles; grant=01; rd_valid at cycle 4 with rd_data=0x41, rd_err=0000 (even parity).
REQ-037 Scenario: req=11 held with the FIFO non-empty for 4 words -> grants 01,10,01,10 in order.
REQ-038 Scenario: rx_word=0xA41 (FE=1, OE=1) -> rd_err=1010; err_cnt increments to 1.
REQ-039 Scenario: RxFE=1, req=11 -> receive_order stays 0 and grant stays 0 indefinitely.
REQ-040 Scenario: rst pulsed during ORD2 -> all outputs 0 immediately, no rd_valid; the next request restarts from ORD1.
REQ-041 Scenario: 300 error words, with err_clr asserted on an error DLVR -> err_cnt saturates at 255, then reads 0 after the clear.
